// File: rtl/toggle_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : toggle_gen_pkg
// Description : Shared encodings for the multi-channel toggle/pulse generator.
//               Per-channel mode values and FSM state values.
// Revision    : 1.0 - initial release
// ============================================================================
package toggle_gen_pkg;

    // Channel operating modes, as presented on the iMode bus
    typedef enum logic [1:0] {
        MODE_RAW     = 2'd0,
        MODE_FREE    = 2'd1,
        MODE_BURST   = 2'd2,
        MODE_ONESHOT = 2'd3
    } mode_t;

    // Per-channel FSM states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : toggle_gen_pkg
`default_nettype wire

// File: rtl/toggle_gen_chan.sv
`default_nettype none
// ============================================================================
// Module      : toggle_gen_chan
// Description : One toggle/pulse generator channel. Raw toggle, free-running
//               square wave, counted burst and one-shot pulse. Mode, phase
//               length and burst length are latched when the channel leaves
//               IDLE; input changes are ignored until it returns to IDLE.
// Ports       : iClk        - system clock
//               iRst_n      - synchronous active-low reset
//               iCE         - tick enable; all counting advances only on iCE
//               iEn         - channel enable; 0 forces IDLE with output low
//               iMode       - operating mode (see toggle_gen_pkg::mode_t)
//               iHalfPeriod - phase length in iCE ticks (0 treated as 1)
//               iBurstLen   - number of high phases in burst mode
//               iStart      - start strobe for burst / one-shot
//               oTSignal    - generated waveform (registered)
//               oBusy       - channel in RUN state (registered)
//               oDone       - one-cycle completion pulse (registered)
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_gen_chan #(
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   iClk,
    input  logic                   iRst_n,
    input  logic                   iCE,
    input  logic                   iEn,
    input  logic [1:0]             iMode,
    input  logic [CNT_WIDTH-1:0]   iHalfPeriod,
    input  logic [BURST_WIDTH-1:0] iBurstLen,
    input  logic                   iStart,
    output logic                   oTSignal,
    output logic                   oBusy,
    output logic                   oDone
);
    import toggle_gen_pkg::*;

    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] c_BURST_ONE = BURST_WIDTH'(1);

    state_t                 r_state;
    mode_t                  r_mode;
    logic [CNT_WIDTH-1:0]   r_heff;
    logic [BURST_WIDTH-1:0] r_blen;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [BURST_WIDTH-1:0] r_pcnt;
    logic                   r_tsig;
    logic                   r_busy;
    logic                   r_done;

    mode_t                  w_mode_in;
    logic [CNT_WIDTH-1:0]   w_heff_in;
    logic                   w_phase_end;

    assign w_mode_in   = mode_t'(iMode);
    // A zero half-period would never terminate a phase, so clamp to one tick
    assign w_heff_in   = (iHalfPeriod == '0) ? c_CNT_ONE : iHalfPeriod;
    // r_heff is never zero, so the subtraction cannot underflow
    assign w_phase_end = iCE && (r_cnt == (r_heff - c_CNT_ONE));

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_RAW;
            r_heff  <= c_CNT_ONE;
            r_blen  <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_tsig  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!iEn) begin
                // Disable aborts silently from any state
                r_state <= ST_IDLE;
                r_tsig  <= 1'b0;
                r_busy  <= 1'b0;
                r_cnt   <= '0;
                r_pcnt  <= '0;
            end else if (r_state == ST_IDLE) begin
                r_mode <= w_mode_in;
                r_heff <= w_heff_in;
                r_blen <= iBurstLen;
                r_cnt  <= '0;
                r_pcnt <= '0;
                case (w_mode_in)
                    MODE_RAW: begin
                        // Output is low in IDLE, so the first inversion is iCE
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_tsig  <= iCE;
                    end
                    MODE_FREE: begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_tsig  <= 1'b0;
                    end
                    MODE_BURST: begin
                        if (iStart) begin
                            if (iBurstLen == '0) begin
                                // Empty burst completes immediately
                                r_done <= 1'b1;
                            end else begin
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                                r_tsig  <= 1'b1;
                            end
                        end
                    end
                    MODE_ONESHOT: begin
                        if (iStart) begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                            r_tsig  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end else begin
                // RUN: iStart is ignored here, so no retrigger is possible
                if (r_mode == MODE_RAW) begin
                    if (iCE) begin
                        r_tsig <= ~r_tsig;
                    end
                end else if (iCE) begin
                    if (w_phase_end) begin
                        r_cnt <= '0;
                        case (r_mode)
                            MODE_FREE: begin
                                r_tsig <= ~r_tsig;
                            end
                            MODE_BURST: begin
                                if (r_tsig) begin
                                    // High-to-low edge closes one pulse
                                    if ((r_pcnt + c_BURST_ONE) == r_blen) begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                        r_done  <= 1'b1;
                                        r_pcnt  <= '0;
                                    end else begin
                                        r_pcnt <= r_pcnt + c_BURST_ONE;
                                    end
                                    r_tsig <= 1'b0;
                                end else begin
                                    r_tsig <= 1'b1;
                                end
                            end
                            MODE_ONESHOT: begin
                                r_state <= ST_IDLE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                                r_tsig  <= 1'b0;
                            end
                            default: begin
                                r_tsig <= r_tsig;
                            end
                        endcase
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
            end
        end
    end

    assign oTSignal = r_tsig;
    assign oBusy    = r_busy;
    assign oDone    = r_done;

endmodule : toggle_gen_chan
`default_nettype wire

// File: rtl/toggle_gen.sv
`default_nettype none
// ============================================================================
// Module      : toggle_gen
// Description : Multi-channel toggle/pulse generator. Each channel is an
//               independent toggle_gen_chan; only the iCE tick is shared.
//               Channel k occupies slice k of every packed bus.
// Ports       : iClk        - system clock
//               iRst_n      - synchronous active-low reset
//               iCE         - shared tick enable
//               iEn         - per-channel enable              [CHANNELS]
//               iMode       - per-channel mode                [2*CHANNELS]
//               iHalfPeriod - per-channel phase length        [CNT_WIDTH*CHANNELS]
//               iBurstLen   - per-channel burst length        [BURST_WIDTH*CHANNELS]
//               iStart      - per-channel start strobe        [CHANNELS]
//               oTSignal    - generated waveforms             [CHANNELS]
//               oBusy       - channel running                 [CHANNELS]
//               oDone       - completion pulses               [CHANNELS]
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_gen #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 16,
    parameter int BURST_WIDTH = 8
) (
    input  logic                            iClk,
    input  logic                            iRst_n,
    input  logic                            iCE,
    input  logic [CHANNELS-1:0]             iEn,
    input  logic [2*CHANNELS-1:0]           iMode,
    input  logic [CNT_WIDTH*CHANNELS-1:0]   iHalfPeriod,
    input  logic [BURST_WIDTH*CHANNELS-1:0] iBurstLen,
    input  logic [CHANNELS-1:0]             iStart,
    output logic [CHANNELS-1:0]             oTSignal,
    output logic [CHANNELS-1:0]             oBusy,
    output logic [CHANNELS-1:0]             oDone
);
    import toggle_gen_pkg::*;

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            toggle_gen_chan #(
                .CNT_WIDTH   (CNT_WIDTH),
                .BURST_WIDTH (BURST_WIDTH)
            ) u_chan (
                .iClk        (iClk),
                .iRst_n      (iRst_n),
                .iCE         (iCE),
                .iEn         (iEn[k]),
                .iMode       (iMode[2*k +: 2]),
                .iHalfPeriod (iHalfPeriod[CNT_WIDTH*k +: CNT_WIDTH]),
                .iBurstLen   (iBurstLen[BURST_WIDTH*k +: BURST_WIDTH]),
                .iStart      (iStart[k]),
                .oTSignal    (oTSignal[k]),
                .oBusy       (oBusy[k]),
                .oDone       (oDone[k])
            );
        end
    endgenerate

endmodule : toggle_gen
`default_nettype wire

// File: tb/tb_toggle_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_gen
// Description : Self-checking bench for toggle_gen. A tick-count reference
//               model (elapsed ticks divided by the phase length) predicts
//               every channel's outputs each cycle; directed scenarios add
//               explicit pulse/edge/busy counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_gen;
    localparam int CH = 4;
    localparam int CW = 16;
    localparam int BW = 8;

    logic               iClk = 1'b0;
    logic               iRst_n;
    logic               iCE;
    logic [CH-1:0]      iEn;
    logic [2*CH-1:0]    iMode;
    logic [CW*CH-1:0]   iHalfPeriod;
    logic [BW*CH-1:0]   iBurstLen;
    logic [CH-1:0]      iStart;
    logic [CH-1:0]      oTSignal;
    logic [CH-1:0]      oBusy;
    logic [CH-1:0]      oDone;

    always #5 iClk = ~iClk;

    toggle_gen #(
        .CHANNELS    (CH),
        .CNT_WIDTH   (CW),
        .BURST_WIDTH (BW)
    ) dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iCE         (iCE),
        .iEn         (iEn),
        .iMode       (iMode),
        .iHalfPeriod (iHalfPeriod),
        .iBurstLen   (iBurstLen),
        .iStart      (iStart),
        .oTSignal    (oTSignal),
        .oBusy       (oBusy),
        .oDone       (oDone)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: running flag, latched settings, ticks since start
    bit     m_run  [CH];
    int     m_mode [CH];
    longint m_heff [CH];
    longint m_b    [CH];
    longint m_t    [CH];
    bit     m_out  [CH];
    bit     m_done [CH];

    // Channel-0 statistics for directed scenarios
    int s_hi, s_busy, s_done, s_inv;
    bit s_prev;

    task automatic model_step();
        longint h;
        longint ph;
        for (int k = 0; k < CH; k++) begin
            m_done[k] = 1'b0;
            if (!iRst_n) begin
                m_run[k] = 1'b0; m_out[k] = 1'b0; m_t[k] = 0;
            end else if (!iEn[k]) begin
                m_run[k] = 1'b0; m_out[k] = 1'b0; m_t[k] = 0;
            end else if (!m_run[k]) begin
                m_mode[k] = int'(iMode[2*k +: 2]);
                h         = longint'(iHalfPeriod[CW*k +: CW]);
                m_heff[k] = (h == 0) ? 1 : h;
                m_b[k]    = longint'(iBurstLen[BW*k +: BW]);
                m_t[k]    = 0;
                case (m_mode[k])
                    0: begin m_run[k] = 1'b1; m_out[k] = iCE; end
                    1: begin m_run[k] = 1'b1; m_out[k] = 1'b0; end
                    2: if (iStart[k]) begin
                           if (m_b[k] == 0) m_done[k] = 1'b1;
                           else begin m_run[k] = 1'b1; m_out[k] = 1'b1; end
                       end
                    default: if (iStart[k]) begin m_run[k] = 1'b1; m_out[k] = 1'b1; end
                endcase
            end else if (m_mode[k] == 0) begin
                if (iCE) m_out[k] = !m_out[k];
            end else if (iCE) begin
                m_t[k] = m_t[k] + 1;
                ph     = m_t[k] / m_heff[k];
                case (m_mode[k])
                    1: m_out[k] = (ph % 2) == 1;
                    2: if (m_t[k] == (2 * m_b[k] - 1) * m_heff[k]) begin
                           m_run[k] = 1'b0; m_out[k] = 1'b0; m_done[k] = 1'b1;
                       end else begin
                           m_out[k] = (ph % 2) == 0;
                       end
                    default: if (m_t[k] == m_heff[k]) begin
                           m_run[k] = 1'b0; m_out[k] = 1'b0; m_done[k] = 1'b1;
                       end
                endcase
            end
        end
    endtask

    task automatic check(input string tag);
        logic [2:0] obs;
        logic [2:0] exp;
        for (int k = 0; k < CH; k++) begin
            obs = {oTSignal[k], oBusy[k], oDone[k]};
            exp = {m_out[k], m_run[k], m_done[k]};
            n_cmp++;
            assert (obs === exp) else begin
                n_err++;
                $error("FAIL %s ch%0d {tsig,busy,done} observed=%b expected=%b", tag, k, obs, exp);
            end
        end
    endtask

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr_stats();
        s_hi = 0; s_busy = 0; s_done = 0; s_inv = 0; s_prev = oTSignal[0];
    endtask

    task automatic cyc(input string tag);
        @(posedge iClk);
        model_step();
        #1;
        check(tag);
        if (oTSignal[0]) s_hi++;
        if (oBusy[0]) s_busy++;
        if (oDone[0]) s_done++;
        if (oTSignal[0] !== s_prev) s_inv++;
        s_prev = oTSignal[0];
    endtask

    task automatic run_n(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    task automatic set_ch(input int k, input int e, input int m, input int h, input int b);
        iEn[k]                = 1'(e);
        iMode[2*k +: 2]       = 2'(m);
        iHalfPeriod[CW*k +: CW] = CW'(h);
        iBurstLen[BW*k +: BW] = BW'(b);
    endtask

    initial begin
        iRst_n = 1'b0; iCE = 1'b0; iEn = '0; iMode = '0;
        iHalfPeriod = '0; iBurstLen = '0; iStart = '0;
        for (int k = 0; k < CH; k++) begin
            m_run[k] = 0; m_mode[k] = 0; m_heff[k] = 1; m_b[k] = 0;
            m_t[k] = 0; m_out[k] = 0; m_done[k] = 0;
        end
        run_n(2, "reset");
        iRst_n = 1'b1;
        iCE    = 1'b1;
        run_n(2, "idle");

        // Reset in the middle of a burst: no oDone, stays idle afterwards
        set_ch(0, 1, 2, 2, 3);
        iStart[0] = 1'b1; cyc("rst_burst_start");
        iStart[0] = 1'b0; run_n(3, "rst_burst_run");
        clr_stats();
        iRst_n = 1'b0; run_n(3, "rst_mid");
        iRst_n = 1'b1; run_n(6, "rst_after");
        check_val("rst_no_done", s_done, 0);
        check_val("rst_no_busy", s_busy, 0);
        set_ch(0, 0, 0, 0, 0); cyc("off");

        // Raw mode with iCE every second cycle
        clr_stats();
        set_ch(0, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            iCE = (i % 2 == 0);
            cyc("raw");
        end
        check_val("raw_inversions", s_inv, 4);
        check_val("raw_final_level", int'(oTSignal[0]), 0);
        iCE = 1'b1;
        set_ch(0, 0, 0, 0, 0); cyc("raw_off");

        // Free-run, H=3 then H changed to 5 mid-run (ignored)
        set_ch(0, 1, 1, 3, 0); run_n(9, "free_h3");
        set_ch(0, 1, 1, 5, 0);
        clr_stats(); run_n(12, "free_h5_ignored");
        check_val("free_period6_edges", s_inv, 4);
        set_ch(0, 0, 1, 0, 0); cyc("free_off");
        set_ch(0, 1, 1, 0, 0);
        cyc("free_h0_enter");
        clr_stats(); run_n(8, "free_h0");
        check_val("free_period2_edges", s_inv, 8);
        set_ch(0, 0, 1, 0, 0); cyc("free_h0_off");

        // Burst H=2 B=3
        clr_stats();
        set_ch(0, 1, 2, 2, 3);
        iStart[0] = 1'b1; cyc("burst_start");
        iStart[0] = 1'b0; run_n(12, "burst_run");
        check_val("burst_busy_cycles", s_busy, 10);
        check_val("burst_high_cycles", s_hi, 6);
        check_val("burst_done_count", s_done, 1);
        // Empty burst
        set_ch(0, 1, 2, 2, 0);
        iStart[0] = 1'b1; cyc("burst_b0");
        check_val("burst_b0_done", int'(oDone[0]), 1);
        check_val("burst_b0_tsig", int'(oTSignal[0]), 0);
        iStart[0] = 1'b0; run_n(2, "burst_b0_after");
        set_ch(0, 0, 0, 0, 0); cyc("burst_off");

        // One-shot H=4 with a retrigger attempt at tick 2
        clr_stats();
        set_ch(0, 1, 3, 4, 0);
        iStart[0] = 1'b1; cyc("os_start");
        iStart[0] = 1'b0; run_n(1, "os_run");
        iStart[0] = 1'b1; cyc("os_retrig");
        iStart[0] = 1'b0; run_n(8, "os_tail");
        check_val("os_high_cycles", s_hi, 4);
        check_val("os_done_count", s_done, 1);
        // Repeat, then drop iEn at tick 2
        clr_stats();
        iStart[0] = 1'b1; cyc("os2_start");
        iStart[0] = 1'b0; run_n(1, "os2_run");
        set_ch(0, 0, 3, 4, 0); cyc("os2_drop");
        check_val("os2_drop_tsig", int'(oTSignal[0]), 0);
        run_n(4, "os2_after");
        check_val("os2_no_done", s_done, 0);

        // All channels concurrently with randomized settings and strobes
        for (int k = 0; k < CH; k++)
            set_ch(k, 1, k, k + 1, k + 1);
        for (int i = 0; i < 3000; i++) begin
            iCE = ($urandom_range(0, 9) < 7);
            for (int k = 0; k < CH; k++) begin
                if ($urandom_range(0, 99) < 3) iEn[k] = ~iEn[k];
                if ($urandom_range(0, 99) < 6) begin
                    iMode[2*k +: 2]         = 2'($urandom_range(0, 3));
                    iHalfPeriod[CW*k +: CW] = CW'($urandom_range(0, 6));
                    iBurstLen[BW*k +: BW]   = BW'($urandom_range(0, 4));
                end
                iStart[k] = ($urandom_range(0, 99) < 10);
            end
            if ($urandom_range(0, 999) < 3) iRst_n = 1'b0;
            else iRst_n = 1'b1;
            cyc("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_toggle_gen
`default_nettype wire
